// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : instr_fetch_unit
// Description : Three-state instruction fetch engine (FETCH -> CAPTURE -> HOLD).
//               Issues one read per instruction to a memory with registered
//               read data, presents the fetched word to decode with a
//               valid/ready handshake, and supports branch/jump redirection.
//
// Ports
//   clk          in   1       rising-edge clock for all state
//   reset        in   1       asynchronous active-high reset
//   mem_read     out  1       read request, high only in FETCH
//   mem_write    out  1       write enable, tied low (fetch never writes)
//   mem_addr     out  ADDR_W  byte address of the word being fetched (= pc)
//   mem_wdata    out  32      write data, tied low
//   mem_rdata    in   32      read data, valid the cycle after mem_read
//   redirect     in   1       taken branch/jump, overrides everything else
//   redirect_pc  in   ADDR_W  new fetch address, bits [1:0] ignored
//   instr        out  32      fetched instruction word
//   instr_pc     out  ADDR_W  address instr was fetched from
//   instr_valid  out  1       instr/instr_pc valid for decode
//   instr_ready  in   1       decode accepts instr this cycle
//   fetch_count  out  16      instructions handed to decode, saturating
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit #(
   parameter int ADDR_W   = 5,
   parameter int RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [15:0]       fetch_count
);

   // Word alignment: instructions are 32-bit, so pc[1:0] is forced to 00
   // everywhere an address enters the PC register.
   localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~(ADDR_W'(3));
   localparam logic [ADDR_W-1:0] c_RESET_PC   = ADDR_W'(RESET_PC) & c_ALIGN_MASK;
   localparam logic [ADDR_W-1:0] c_PC_STEP    = ADDR_W'(4);
   localparam logic [15:0]       c_COUNT_MAX  = 16'hFFFF;

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_CAPTURE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_instr_valid;
   logic [15:0]       r_fetch_count;

   logic [ADDR_W-1:0] w_redirect_aligned;
   logic              w_accept;

   assign w_redirect_aligned = redirect_pc & c_ALIGN_MASK;

   // In HOLD the word is always valid, so ready alone completes the handshake.
   assign w_accept = (r_state == S_HOLD) && instr_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_FETCH;
         r_pc          <= c_RESET_PC;
         r_instr       <= 32'd0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
         r_fetch_count <= 16'd0;
      end else begin
         // An accept counts even when a redirect arrives in the same cycle:
         // decode has consumed the word, the redirect only changes what follows.
         if (w_accept && (r_fetch_count != c_COUNT_MAX)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
         end

         if (redirect) begin
            // Taking the FSM back to FETCH without passing CAPTURE drops any
            // read already in flight; its data is simply never sampled.
            r_pc          <= w_redirect_aligned;
            r_instr_valid <= 1'b0;
            r_state       <= S_FETCH;
         end else begin
            unique case (r_state)
               S_FETCH: begin
                  r_state <= S_CAPTURE;
               end
               S_CAPTURE: begin
                  r_instr       <= mem_rdata;
                  r_instr_pc    <= r_pc;
                  r_instr_valid <= 1'b1;
                  r_pc          <= r_pc + c_PC_STEP;  // wraps modulo 2^ADDR_W
                  r_state       <= S_HOLD;
               end
               S_HOLD: begin
                  if (instr_ready) begin
                     r_instr_valid <= 1'b0;
                     r_state       <= S_FETCH;
                  end
               end
               default: begin
                  r_instr_valid <= 1'b0;
                  r_state       <= S_FETCH;
               end
            endcase
         end
      end
   end

   // Gating with reset keeps the request low for the whole reset pulse and
   // lets it rise in the very first cycle after release.
   assign mem_read  = (r_state == S_FETCH) && !reset;
   assign mem_write = 1'b0;
   assign mem_addr  = r_pc;
   assign mem_wdata = 32'd0;

   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;
   assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_instr_fetch_unit
// Description : Directed, self-checking bench for instr_fetch_unit. A small
//               registered-read memory model feeds the DUT; expected
//               (pc, word) pairs are queued when a fetch is set up and popped
//               when the DUT presents instr_valid.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              redirect = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready = 1'b1;
   logic [15:0]       fetch_count;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [31:0]       word;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem [0:7];
   int          checks    = 0;
   int          failures  = 0;
   int          exp_count = 0;

   instr_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (0)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   // Registered-read instruction memory
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= mem[mem_addr[ADDR_W-1:2]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [ADDR_W-1:0] pc);
      exp_t e;
      e.pc   = pc;
      e.word = mem[pc[ADDR_W-1:2]];
      exp_q.push_back(e);
   endtask

   // Wait (bounded) for instr_valid at a falling edge, then pop and compare.
   task automatic expect_instr(input string tag);
      exp_t e;
      bit   seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_valid"}, {31'd0, seen}, 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (seen) begin
            check({tag, "_instr"}, instr, e.word);
            check({tag, "_pc"}, 32'(instr_pc), 32'(e.pc));
         end
      end
   endtask

   initial begin
      mem[0] = 32'h00430820;
      mem[1] = 32'h20410004;
      for (int i = 2; i < 8; i++) mem[i] = 32'hA5A5_0000 + 32'(i);

      // ---- reset state
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_mem_read", {31'd0, mem_read}, 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_instr", instr, 32'd0);
      check("rst_instr_pc", 32'(instr_pc), 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_count", 32'(fetch_count), 32'd0);
      check("rst_mem_write", {31'd0, mem_write}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_mem_read", {31'd0, mem_read}, 32'd1);
      check("post_rst_mem_addr", 32'(mem_addr), 32'd0);

      // ---- two back-to-back fetches with ready held high
      push_exp(5'd0);
      push_exp(5'd4);
      expect_instr("seq0");
      @(negedge clk);
      check("seq0_held_1cyc", {31'd0, instr_valid}, 32'd0);
      expect_instr("seq1");
      @(negedge clk);
      check("seq1_held_1cyc", {31'd0, instr_valid}, 32'd0);
      exp_count = 2;
      check("seq_count", 32'(fetch_count), 32'(exp_count));

      // ---- decode stall: outputs frozen, no read issued
      instr_ready = 1'b0;
      push_exp(5'd8);
      expect_instr("stall");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_instr", instr, mem[2]);
         check("stall_pc", 32'(instr_pc), 32'd8);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_no_read", {31'd0, mem_read}, 32'd0);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      check("stall_next_read", {31'd0, mem_read}, 32'd1);
      check("stall_next_addr", 32'(mem_addr), 32'd12);
      exp_count = 3;
      check("stall_count", 32'(fetch_count), 32'(exp_count));

      // ---- redirect during CAPTURE (unaligned target)
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 5'h13;
      @(negedge clk);
      redirect = 1'b0;
      check("redir_valid", {31'd0, instr_valid}, 32'd0);
      check("redir_addr", 32'(mem_addr), 32'h10);
      check("redir_read", {31'd0, mem_read}, 32'd1);
      push_exp(5'h10);
      expect_instr("redir");
      exp_count = 4;

      // ---- wrap-around from pc 28
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 5'd28;
      @(negedge clk);
      redirect = 1'b0;
      push_exp(5'd28);
      expect_instr("wrap");
      @(negedge clk);
      check("wrap_next_addr", 32'(mem_addr), 32'd0);
      exp_count = 5;
      check("wrap_count", 32'(fetch_count), 32'(exp_count));

      // ---- redirect and accept in the same HOLD cycle
      push_exp(5'd0);
      expect_instr("redir_acc");
      redirect    = 1'b1;
      redirect_pc = 5'd8;
      @(negedge clk);
      redirect = 1'b0;
      exp_count = 6;
      check("redir_acc_count", 32'(fetch_count), 32'(exp_count));
      check("redir_acc_valid", {31'd0, instr_valid}, 32'd0);
      check("redir_acc_addr", 32'(mem_addr), 32'd8);

      // ---- reset pulsed during CAPTURE
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_instr", instr, 32'd0);
      check("midrst_pc", 32'(instr_pc), 32'd0);
      check("midrst_valid", {31'd0, instr_valid}, 32'd0);
      check("midrst_count", 32'(fetch_count), 32'd0);
      check("midrst_read", {31'd0, mem_read}, 32'd0);
      check("midrst_addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_rel_read", {31'd0, mem_read}, 32'd1);
      check("midrst_rel_addr", 32'(mem_addr), 32'd0);
      push_exp(5'd0);
      expect_instr("midrst_fetch");

      // ---- saturation of fetch_count
      instr_ready = 1'b0;
      force dut.r_fetch_count = 16'hFFFF;
      #1;
      release dut.r_fetch_count;
      #1;
      check("sat_preload", 32'(fetch_count), 32'h0000FFFF);
      instr_ready = 1'b1;
      @(negedge clk);
      check("sat_valid_drop", {31'd0, instr_valid}, 32'd0);
      check("sat_count", 32'(fetch_count), 32'h0000FFFF);

      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 5, width of the byte address bus to the instruction memory.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset; bits [1:0] SHALL be treated as 00.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk and reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 mem_read  output  1  read request to the instruction memory.
REQ-007 mem_write  output  1  write enable to the instruction memory; constant 0.
REQ-008 mem_addr  output  ADDR_W  byte address of the word being fetched.
REQ-009 mem_wdata  output  32  write data to the instruction memory; constant 0.
REQ-010 mem_rdata  input  32  registered read data; valid on the cycle after the edge that sampled mem_read=1.
REQ-011 redirect  input  1  branch/jump taken; replaces the PC.
REQ-012 redirect_pc  input  ADDR_W  new fetch address; bits [1:0] ignored.
REQ-013 instr  output  32  fetched instruction word.
REQ-014 instr_pc  output  ADDR_W  address the instr word was fetched from.
REQ-015 instr_valid  output  1  instr/instr_pc are valid for decode.
REQ-016 instr_ready  input  1  decode accepts instr on this cycle when instr_valid=1.
REQ-017 fetch_count  output  16  number of instructions handed to decode, saturating.

Function
REQ-018 FSM states: FETCH, CAPTURE, HOLD.
REQ-019 FETCH: mem_read=1 and mem_addr=pc; next state is CAPTURE.
REQ-020 CAPTURE: mem_read=0; at the clock edge, instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4; next state is HOLD.
REQ-021 HOLD: instr_valid=1 and outputs stable; on instr_ready=1, instr_valid<=0, fetch_count increments and the next state is FETCH; otherwise HOLD.
REQ-022 Fetch latency: 2 cycles from entering FETCH to instr_valid=1; sustained throughput is 1 instruction per 3 cycles with instr_ready held at 1.
REQ-023 PC arithmetic SHALL be modulo 2^ADDR_W (pc 28 + 4 = 0 for ADDR_W=5); pc[1:0] SHALL always be 00.
REQ-024 redirect=1 in any state SHALL take priority: pc<=redirect_pc with [1:0]=00, instr_valid<=0, next state FETCH, and any in-flight CAPTURE data is discarded.
REQ-025 If redirect=1 and instr_ready=1 occur together in HOLD, the held instruction SHALL count as accepted (fetch_count increments), and then the redirect applies.
REQ-026 fetch_count SHALL saturate at 0xFFFF.
REQ-027 mem_addr SHALL equal pc in every state; mem_read SHALL be high only in FETCH.
REQ-028 instr and instr_pc SHALL change only in CAPTURE or on reset.

Reset
REQ-029 Asserting reset SHALL immediately set state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_count=0, and mem_read=0 for as long as reset is held.
REQ-030 Reset asserted mid-fetch SHALL discard the pending read; the first fetch after release SHALL be from RESET_PC.
REQ-031 After reset is released, mem_read SHALL assert on the first clock cycle.

Verification
REQ-032 Memory word0=0x00430820 and word4=0x20410004, instr_ready=1 -> instr=0x00430820 with instr_pc=0, then 0x20410004 with instr_pc=4, each held for 1 cycle; fetch_count=2.
REQ-033 instr_ready=0 for 5 cycles after the first instr_valid -> instr and instr_pc stay stable and no mem_read is issued; after ready=1, the next fetch is from address 4.
REQ-034 redirect=1 with redirect_pc=0x13 during CAPTURE -> instr_valid stays 0 and the next mem_addr=0x10.
REQ-035 Fetch from pc=28 -> instr_pc=28 and the next mem_addr=0 (wrap-around).
REQ-036 reset pulsed during CAPTURE -> all outputs read 0, and the first mem_addr after release is 0.
REQ-037 Force fetch_count to 0xFFFF and accept one more instruction -> fetch_count remains 0xFFFF.
